// File: rtl/ones_window_classifier.sv
// Sums clamped per-sample ones counts over WINDOW_LEN accepted samples and
// hands out the sum plus a threshold class bit. ONES_WINDOW_OVERRUN_EN adds a sticky overrun_o.
module ones_window_classifier #(
    parameter int INPUT_FEATURES = 4,
    parameter int WINDOW_LEN     = 8,
    parameter int THRESHOLD      = 16,
    localparam int CNT_W = $clog2(INPUT_FEATURES + 1),
    localparam int SUM_W = $clog2(INPUT_FEATURES * WINDOW_LEN + 1),
    localparam int IDX_W = $clog2(WINDOW_LEN)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [CNT_W-1:0] ones_i,
    input  logic             ones_valid_i,
    output logic             ones_ready_o,
    input  logic             clear_i,
    input  logic             result_ready_i,
    output logic             result_valid_o,
    output logic [SUM_W-1:0] sum_o,
    output logic             class_o,
    output logic [IDX_W-1:0] sample_idx_o
`ifdef ONES_WINDOW_OVERRUN_EN
    ,
    output logic             overrun_o
`endif
);

    typedef enum logic {ACCUM, RESULT} state_t;

    localparam logic [CNT_W-1:0] MAX_ONES = CNT_W'(INPUT_FEATURES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW_LEN - 1);
    localparam logic [31:0]      THRESH_U = THRESHOLD;

    state_t           state;
    logic [SUM_W-1:0] acc;
    logic [CNT_W-1:0] clamped;
    logic [SUM_W-1:0] next_sum;
    logic             accept;

    // Out-of-range counts are clamped so the accumulator can never wrap.
    assign clamped  = (ones_i > MAX_ONES) ? MAX_ONES : ones_i;
    assign next_sum = acc + SUM_W'(clamped);
    assign accept   = ones_valid_i && ones_ready_o;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state          <= ACCUM;
            acc            <= '0;
            sample_idx_o   <= '0;
            sum_o          <= '0;
            class_o        <= 1'b0;
            result_valid_o <= 1'b0;
            ones_ready_o   <= 1'b1;
        end else if (clear_i) begin
            // Abort drops any partial window and pending result; sum/class keep history.
            state          <= ACCUM;
            acc            <= '0;
            sample_idx_o   <= '0;
            result_valid_o <= 1'b0;
            ones_ready_o   <= 1'b1;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (sample_idx_o == LAST_IDX) begin
                            sum_o          <= next_sum;
                            class_o        <= ({{(32-SUM_W){1'b0}}, next_sum} >= THRESH_U);
                            acc            <= '0;
                            sample_idx_o   <= '0;
                            state          <= RESULT;
                            result_valid_o <= 1'b1;
                            ones_ready_o   <= 1'b0;
                        end else begin
                            acc          <= next_sum;
                            sample_idx_o <= sample_idx_o + IDX_W'(1);
                        end
                    end
                end
                RESULT: begin
                    if (result_ready_i) begin
                        state          <= ACCUM;
                        result_valid_o <= 1'b0;
                        ones_ready_o   <= 1'b1;
                    end
                end
                default: begin
                    state          <= ACCUM;
                    result_valid_o <= 1'b0;
                    ones_ready_o   <= 1'b1;
                end
            endcase
        end
    end

`ifdef ONES_WINDOW_OVERRUN_EN
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)
            overrun_o <= 1'b0;
        else if (clear_i)
            overrun_o <= 1'b0;
        else if (ones_valid_i && !ones_ready_o)
            overrun_o <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_ones_window_classifier.sv
// Scoreboard bench for ones_window_classifier: directed windows, mid-result
// reset and randomized traffic checked against a window-list reference model.
module tb_ones_window_classifier;

    typedef struct {
        int sum;
        bit cls;
    } exp_t;

    logic       clock_i        = 1'b1;
    logic       reset_i        = 1'b1;
    logic [2:0] ones_i         = '0;
    logic       ones_valid_i   = 1'b0;
    logic       clear_i        = 1'b0;
    logic       result_ready_i = 1'b0;
    logic       ones_ready_o;
    logic       result_valid_o;
    logic [5:0] sum_o;
    logic       class_o;
    logic [2:0] sample_idx_o;
`ifdef ONES_WINDOW_OVERRUN_EN
    logic       overrun_o;
`endif

    ones_window_classifier #(
        .INPUT_FEATURES(4),
        .WINDOW_LEN(8),
        .THRESHOLD(16)
    ) dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .ones_i(ones_i),
        .ones_valid_i(ones_valid_i),
        .ones_ready_o(ones_ready_o),
        .clear_i(clear_i),
        .result_ready_i(result_ready_i),
        .result_valid_o(result_valid_o),
        .sum_o(sum_o),
        .class_o(class_o),
        .sample_idx_o(sample_idx_o)
`ifdef ONES_WINDOW_OVERRUN_EN
        ,
        .overrun_o(overrun_o)
`endif
    );

    always #5 clock_i = ~clock_i;

    int   n_vec  = 0;
    int   n_fail = 0;
    int   win[$];
    exp_t q[$];
    bit   pending  = 1'b0;
    int   last_sum = 0;
    bit   last_cls = 1'b0;
    bit   m_ovr    = 1'b0;
    bit   mon_en   = 1'b0;

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        win.delete();
        q.delete();
        pending  = 1'b0;
        last_sum = 0;
        last_cls = 1'b0;
        m_ovr    = 1'b0;
    endfunction

    // Reference: list of accepted clamped samples; a full list becomes one expected result.
    task automatic model_step();
        int c;
        int s;
        if (clear_i) begin
            if (pending && q.size() > 0) void'(q.pop_back());
            pending = 1'b0;
            win.delete();
            m_ovr = 1'b0;
        end else if (pending) begin
            if (ones_valid_i) m_ovr = 1'b1;
            if (result_ready_i) pending = 1'b0;
        end else if (ones_valid_i) begin
            c = (int'(ones_i) > 4) ? 4 : int'(ones_i);
            win.push_back(c);
            if (win.size() == 8) begin
                s = 0;
                foreach (win[i]) s += win[i];
                last_sum = s;
                last_cls = (s >= 16);
                q.push_back('{s, (s >= 16)});
                win.delete();
                pending = 1'b1;
            end
        end
    endtask

    task automatic drive(bit v, int o, bit c, bit r);
        ones_valid_i   = v;
        ones_i         = 3'(o);
        clear_i        = c;
        result_ready_i = r;
        @(posedge clock_i);
        model_step();
        #2;
    endtask

    always @(negedge clock_i) begin : monitor
        exp_t e;
        if (mon_en) begin
            chk("result_valid", int'(result_valid_o), int'(pending));
            chk("ones_ready", int'(ones_ready_o), int'(!pending));
            chk("sample_idx", int'(sample_idx_o), win.size());
            chk("sum_hold", int'(sum_o), last_sum);
            chk("class_hold", int'(class_o), int'(last_cls));
`ifdef ONES_WINDOW_OVERRUN_EN
            chk("overrun", int'(overrun_o), int'(m_ovr));
`endif
            if (result_valid_o && result_ready_i && !clear_i) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL handshake: result offered sum=%0d, none expected", sum_o);
                end else begin
                    e = q.pop_front();
                    chk("result_sum", int'(sum_o), e.sum);
                    chk("result_class", int'(class_o), int'(e.cls));
                end
            end
        end
    end

    task automatic check_reset_vals(string tag);
        chk({tag, "_valid"}, int'(result_valid_o), 0);
        chk({tag, "_sum"}, int'(sum_o), 0);
        chk({tag, "_class"}, int'(class_o), 0);
        chk({tag, "_idx"}, int'(sample_idx_o), 0);
        chk({tag, "_ready"}, int'(ones_ready_o), 1);
    endtask

    initial begin
        model_reset();
        #15 reset_i = 1'b0;
        #1 check_reset_vals("reset");
        @(posedge clock_i);
        #2 mon_en = 1'b1;

        // full-threshold window, consumer always ready
        repeat (8) drive(1'b1, 2, 1'b0, 1'b1);
        repeat (2) drive(1'b0, 0, 1'b0, 1'b1);

        // clamping of an out-of-range count
        repeat (7) drive(1'b1, 1, 1'b0, 1'b1);
        drive(1'b1, 7, 1'b0, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b1);

        // back-pressured result with samples still offered, then a zero window
        repeat (8) drive(1'b1, 3, 1'b0, 1'b0);
        repeat (5) drive(1'b1, 3, 1'b0, 1'b0);
        drive(1'b1, 3, 1'b0, 1'b1);
        repeat (8) drive(1'b1, 0, 1'b0, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b1);

        // clear mid-window drops the partial sum and the coincident sample
        repeat (3) drive(1'b1, 4, 1'b0, 1'b1);
        drive(1'b1, 4, 1'b1, 1'b1);
        repeat (8) drive(1'b1, 4, 1'b0, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b1);

        // idle gaps between valid samples
        repeat (8) begin
            drive(1'b1, 1, 1'b0, 1'b1);
            drive(1'b0, 1, 1'b0, 1'b1);
        end
        drive(1'b0, 0, 1'b0, 1'b1);

        // asynchronous reset while a result is pending
        repeat (8) drive(1'b1, 4, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b0);
        mon_en  = 1'b0;
        reset_i = 1'b1;
        model_reset();
        #1 check_reset_vals("midreset");
        @(negedge clock_i);
        reset_i = 1'b0;
        @(posedge clock_i);
        #2 mon_en = 1'b1;

        repeat (600)
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
                  $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7);

        repeat (3) drive(1'b0, 0, 1'b0, 1'b1);
        chk("leftover_expected", q.size(), 0);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
